ab_div: RTL and testbench

- Sequential unsigned restoring divider; the inverse operation to the team's combinational A+B / A-B / A*B arithmetic block.
- Takes the same 4-bit A and B operands and produces quotient and remainder, one quotient bit per clock.
- Uses a start/done handshake so it can sit beside the combinational block in the same arithmetic datapath.

---
 rtl/ab_defs.sv | 14 +
 rtl/ab_div_step.sv | 21 ++
 rtl/ab_div.sv | 99 +++++++++
 tb/tb_ab_div.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/ab_defs.sv
// Shared definitions for the sequential A/B divider: FSM encodings and
// the quotient reported on a divide-by-zero.
package ab_defs;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  // Sliced down to WIDTH bits by the user; covers the full legal range.
  localparam logic [15:0] DBZ_QUOT = 16'hFFFF;

endpackage

// File: rtl/ab_div_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor when it fits.
module ab_div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  logic [WIDTH:0] rem_t;

  assign rem_t  = {rem_i, bit_i};
  assign qbit_o = (rem_t >= {1'b0, div_i});
  // When the divisor fits, rem_t - div_i < div_i, so the low WIDTH bits
  // of the difference are exact.
  assign rem_o  = qbit_o ? (rem_t[WIDTH-1:0] - div_i) : rem_t[WIDTH-1:0];

endmodule

// File: rtl/ab_div.sv
// Sequential unsigned restoring divider with a start/done handshake,
// producing one quotient bit per clock, MSB first.
module ab_div
  import ab_defs::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             dbz
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, rem_q, quo_q;
  logic [WIDTH-1:0] q_q, r_q;
  logic             busy_q, done_q, dbz_q, dbz_pend_q;
  logic [WIDTH-1:0] rem_d;
  logic             qbit_d;

  ab_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .bit_i  (a_q[cnt_q]),
    .div_i  (b_q),
    .rem_o  (rem_d),
    .qbit_o (qbit_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      q_q        <= '0;
      r_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      dbz_pend_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q        <= A;
            b_q        <= B;
            rem_q      <= '0;
            quo_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= S_CALC;
            // A zero divisor spends a single CALC cycle so both paths
            // share the FIN load and the documented two-cycle latency.
            dbz_pend_q <= (B == '0);
            cnt_q      <= (B == '0) ? '0 : CW'(WIDTH - 1);
          end
        end
        S_CALC: begin
          rem_q        <= rem_d;
          quo_q[cnt_q] <= qbit_d;
          if (cnt_q == '0) state_q <= S_FIN;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        S_FIN: begin
          if (dbz_pend_q) begin
            q_q <= DBZ_QUOT[WIDTH-1:0];
            r_q <= a_q;
          end else begin
            q_q <= quo_q;
            r_q <= rem_q;
          end
          dbz_q   <= dbz_pend_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Q    = q_q;
  assign R    = r_q;
  assign busy = busy_q;
  assign done = done_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_ab_div.sv
// Directed and exhaustive checks of the 4-bit sequential divider.
module tb_ab_div;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [3:0] A, B, Q, R;
  logic       busy, done, dbz;

  int tests = 0;
  int fails = 0;

  ab_div #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .Q(Q), .R(R), .busy(busy), .done(done), .dbz(dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a, b, q, r;
    logic       dbz;
    int         lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Accepts one division and returns the number of edges from the start
  // edge until done is seen (-1 on timeout). Returns at the done cycle.
  task automatic run_div(input logic [3:0] a, input logic [3:0] b, output int lat);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat, ndone, last_t, qv, rv;
    rst = 1'b1; start = 1'b0; A = '0; B = '0;

    vecs[0]  = '{4'd11, 4'd7,  4'd1,  4'd4, 1'b0, 5};
    vecs[1]  = '{4'd6,  4'd5,  4'd1,  4'd1, 1'b0, 5};
    vecs[2]  = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0, 5};
    vecs[3]  = '{4'd3,  4'd4,  4'd0,  4'd3, 1'b0, 5};
    vecs[4]  = '{4'd9,  4'd0,  4'd15, 4'd9, 1'b1, 2};
    vecs[5]  = '{4'd0,  4'd5,  4'd0,  4'd0, 1'b0, 5};
    vecs[6]  = '{4'd5,  4'd5,  4'd1,  4'd0, 1'b0, 5};
    vecs[7]  = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0, 5};
    vecs[8]  = '{4'd14, 4'd3,  4'd4,  4'd2, 1'b0, 5};
    vecs[9]  = '{4'd0,  4'd0,  4'd15, 4'd0, 1'b1, 2};
    vecs[10] = '{4'd1,  4'd15, 4'd0,  4'd1, 1'b0, 5};
    vecs[11] = '{4'd12, 4'd2,  4'd6,  4'd0, 1'b0, 5};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_Q", Q, 0); chk("rst_R", R, 0); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0); chk("rst_dbz", dbz, 0);
    rst = 1'b0;

    // Table-driven vectors; busy must be high during the run.
    foreach (vecs[i]) begin
      run_div(vecs[i].a, vecs[i].b, lat);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_Q", i), Q, vecs[i].q);
      chk($sformatf("v%0d_R", i), R, vecs[i].r);
      chk($sformatf("v%0d_dbz", i), dbz, vecs[i].dbz);
      chk($sformatf("v%0d_busy_at_done", i), busy, 0);
      if (!vecs[i].dbz) chk($sformatf("v%0d_inv", i), Q * vecs[i].b + R, vecs[i].a);
      @(negedge clk);
      chk($sformatf("v%0d_pulse", i), done, 0);
      chk($sformatf("v%0d_hold_Q", i), Q, vecs[i].q);
    end

    // Start during CALC is ignored; operand changes mid-run have no effect.
    @(negedge clk);
    A = 4'd11; B = 4'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("busy_in_calc", busy, 1);
    @(posedge clk); #1 A = 4'd15; B = 4'd1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0; A = 4'd3; B = 4'd2;
    ndone = 0; qv = -1; rv = -1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done) begin ndone++; qv = Q; rv = R; end
    end
    chk("ign_ndone", ndone, 1); chk("ign_Q", qv, 1); chk("ign_R", rv, 4);

    // Reset mid-CALC aborts with no done pulse.
    @(negedge clk);
    A = 4'd6; B = 4'd5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("abort_Q", Q, 0); chk("abort_R", R, 0);
    chk("abort_busy", busy, 0); chk("abort_done", done, 0);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_nodone", ndone, 0);
    run_div(4'd6, 4'd5, lat);
    chk("post_abort_lat", lat, 5); chk("post_abort_Q", Q, 1); chk("post_abort_R", R, 1);

    // Start held high: back-to-back divisions every 6 cycles.
    @(negedge clk);
    A = 4'd14; B = 4'd3; start = 1'b1;
    ndone = 0; last_t = -1;
    for (int k = 1; k <= 26; k++) begin
      @(posedge clk); @(negedge clk);
      if (done) begin
        ndone++;
        chk("held_Q", Q, 4); chk("held_R", R, 2);
        chk("held_gap", k - last_t, (last_t < 0) ? k + 1 : 6);
        last_t = k;
      end
    end
    start = 1'b0;
    chk("held_ndone", ndone, 4);
    repeat (10) @(negedge clk);

    // All 256 operand pairs against a behavioural reference.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_div(4'(a), 4'(b), lat);
        if (b == 0) begin
          chk($sformatf("ex_%0d_%0d_lat", a, b), lat, 2);
          chk($sformatf("ex_%0d_%0d_Q", a, b), Q, 15);
          chk($sformatf("ex_%0d_%0d_R", a, b), R, a);
          chk($sformatf("ex_%0d_%0d_dbz", a, b), dbz, 1);
        end else begin
          chk($sformatf("ex_%0d_%0d_lat", a, b), lat, 5);
          chk($sformatf("ex_%0d_%0d_Q", a, b), Q, a / b);
          chk($sformatf("ex_%0d_%0d_R", a, b), R, a % b);
          chk($sformatf("ex_%0d_%0d_dbz", a, b), dbz, 0);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
